// File: rtl/csi_pixel_packer.sv
// Packs the receiver pixel/event stream into 32-bit FIFO words: one header per frame,
// two pixels per data word and one trailer per frame. Overflowing frames are dropped.
`timescale 1ns/1ps
module csi_pixel_packer #(
  parameter int QDEPTH = 4
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [9:0]  pix_data,
  input  logic        pix_valid,
  input  logic        fs,
  input  logic        fe,
  input  logic        ls,
  input  logic        le,
  input  logic [5:0]  data_type,
  input  logic        wr_full,
  output logic [31:0] wr_data,
  output logic        wr_en,
  output logic [7:0]  frame_cnt,
  output logic        ovf_sticky,
  input  logic        ovf_clr,
  output logic        frame_int,
  output logic [1:0]  fsm_state
);

  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DROP = 2'd2} state_t;

  state_t      state, state_n;
  logic        fe_pend, fe_pend_n;
  logic        hdr_pend, hdr_pend_n;
  logic        hdr_en, hdr_en_n;
  logic [5:0]  dt_reg, dt_n;
  logic        half, half_n, half_c;
  logic [9:0]  even, even_n, pix_m;
  logic [15:0] line_cnt, line_n, line_inc;

  logic        push, push_ok, is_trailer, overflow, full, pop;
  logic [31:0] push_word, trailer_word;

  logic [31:0] mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  function automatic logic [31:0] hdr_word(input logic [5:0] dt, input logic [7:0] fn);
    return {8'hF5, 2'b00, dt, 8'h00, fn};
  endfunction

  assign fsm_state    = state;
  assign pix_m        = (dt_reg == 6'h28) ? {2'b00, pix_data[7:0]} : pix_data;
  assign half_c       = half & ~ls;
  assign line_inc     = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
  assign trailer_word = {8'hFE, 8'h00, line_cnt};

  assign full     = (count == (AW+1)'(QDEPTH));
  assign pop      = (count != '0) && !wr_full;
  assign wr_en    = pop;
  assign wr_data  = (count != '0) ? mem[rd_ptr] : 32'h0;
  // A pop in the same cycle frees the slot, so only a stalled full queue overflows.
  assign overflow = push && full && !pop;
  assign push_ok  = push && !overflow;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    push       = 1'b0;
    push_word  = 32'h0;
    is_trailer = 1'b0;
    half_n     = half;
    even_n     = even;
    line_n     = line_cnt;
    fe_pend_n  = fe_pend;
    hdr_pend_n = hdr_pend;
    hdr_en_n   = hdr_en;
    dt_n       = dt_reg;
    case (state)
      IDLE, DROP: begin
        if (fs) begin
          dt_n = data_type;
          if (enable) begin
            push      = 1'b1;
            push_word = hdr_word(data_type, frame_cnt);
            state_n   = FRAME;
            line_n    = 16'h0;
            half_n    = 1'b0;
            fe_pend_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      FRAME: begin
        if (hdr_pend) begin
          hdr_pend_n = 1'b0;
          line_n     = 16'h0;
          half_n     = 1'b0;
          if (hdr_en) begin
            push      = 1'b1;
            push_word = hdr_word(dt_reg, frame_cnt);
          end else begin
            state_n = IDLE;
          end
        end else if (fs) begin
          // Missing fe: close the old frame now, open the new one next cycle.
          push       = 1'b1;
          push_word  = trailer_word;
          is_trailer = 1'b1;
          hdr_pend_n = 1'b1;
          hdr_en_n   = enable;
          dt_n       = data_type;
          fe_pend_n  = 1'b0;
        end else if (fe_pend) begin
          push       = 1'b1;
          push_word  = trailer_word;
          is_trailer = 1'b1;
          fe_pend_n  = 1'b0;
          state_n    = IDLE;
        end else begin
          half_n = half_c;
          if (pix_valid) begin
            if (half_c) begin
              push      = 1'b1;
              push_word = {6'b0, pix_m, 6'b0, even};
              half_n    = 1'b0;
            end else if (le) begin
              push      = 1'b1;
              push_word = {16'h0, 6'b0, pix_m};
              half_n    = 1'b0;
            end else begin
              half_n = 1'b1;
              even_n = pix_m;
            end
          end else if (le && half_c) begin
            push      = 1'b1;
            push_word = {16'h0, 6'b0, even};
          end
          if (le) begin
            half_n = 1'b0;
            line_n = line_inc;
          end
          if (fe) begin
            if (push) begin
              fe_pend_n = 1'b1;
            end else begin
              push       = 1'b1;
              push_word  = trailer_word;
              is_trailer = 1'b1;
              state_n    = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (overflow) begin
      state_n    = DROP;
      fe_pend_n  = 1'b0;
      hdr_pend_n = 1'b0;
      half_n     = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      fe_pend    <= 1'b0;
      hdr_pend   <= 1'b0;
      hdr_en     <= 1'b0;
      dt_reg     <= 6'h0;
      half       <= 1'b0;
      even       <= 10'h0;
      line_cnt   <= 16'h0;
      frame_cnt  <= 8'h0;
      frame_int  <= 1'b0;
      ovf_sticky <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      fe_pend   <= fe_pend_n;
      hdr_pend  <= hdr_pend_n;
      hdr_en    <= hdr_en_n;
      dt_reg    <= dt_n;
      half      <= half_n;
      even      <= even_n;
      line_cnt  <= line_n;
      frame_int <= push_ok && is_trailer;
      if (push_ok && is_trailer) frame_cnt <= frame_cnt + 8'd1;
      if (overflow)     ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_csi_pixel_packer.sv
// Directed bench for csi_pixel_packer: hand-computed word streams compared through an
// expected queue, plus status checks on frame_cnt, frame_int, ovf_sticky and state.
`timescale 1ns/1ps
module tb_csi_pixel_packer;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        fs = 1'b0, fe = 1'b0, ls = 1'b0, le = 1'b0;
  logic [5:0]  data_type = 6'h2B;
  logic        wr_full = 1'b0;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [7:0]  frame_cnt;
  logic        ovf_sticky;
  logic        ovf_clr = 1'b0;
  logic        frame_int;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;
  int fi_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  csi_pixel_packer #(.QDEPTH(4)) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .pix_data(pix_data),
    .pix_valid(pix_valid), .fs(fs), .fe(fe), .ls(ls), .le(le),
    .data_type(data_type), .wr_full(wr_full), .wr_data(wr_data), .wr_en(wr_en),
    .frame_cnt(frame_cnt), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .frame_int(frame_int), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  // output monitor: words accepted by the FIFO and frame_int pulses
  always @(negedge pclk) begin
    if (reset_n && wr_en) got_q.push_back(wr_data);
    if (reset_n && frame_int) fi_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle of input events, applied just after a rising edge
  task automatic ev(input logic f_s, input logic f_e, input logic l_s, input logic l_e,
                    input logic p_v, input logic [9:0] px);
    fs = f_s; fe = f_e; ls = l_s; le = l_e; pix_valid = p_v; pix_data = px;
    @(posedge pclk); #1;
    fs = 1'b0; fe = 1'b0; ls = 1'b0; le = 1'b0; pix_valid = 1'b0; pix_data = '0;
  endtask

  task automatic pix(input logic [9:0] px);
    ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, px);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // scoreboard: compare accepted words against the expected queue
  task automatic check_stream(input string tag);
    logic [31:0] e, g;
    idle(12);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxxxxxx;
      chk({tag, "_word"}, g, e);
    end
    got_q.delete();
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    idle(3);
    @(negedge pclk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("rst_frame_int", 32'(frame_int), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    @(posedge pclk); #1;
    reset_n = 1'b1;
    idle(2);

    // 4x2 RAW10 frame, pixels 1..8
    enable = 1'b1; data_type = 6'h2B;
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(1); pix(2); pix(3); pix(4);
    ev(0, 0, 0, 1, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(5); pix(6); pix(7); pix(8);
    ev(0, 0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0, 0);
    exp_q = '{32'hF52B0000, 32'h00020001, 32'h00040003, 32'h00060005,
              32'h00080007, 32'hFE000002};
    check_stream("raw10_frame");
    chk("raw10_frame_int", 32'(fi_count), 32'd1);
    chk("raw10_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("raw10_idle", 32'(fsm_state), 32'd0);

    // RAW8 frame, 3-pixel line with masking and zero pad
    data_type = 6'h28;
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(10'h3FF); pix(10'h002); pix(10'h3FF);
    ev(0, 0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0, 0);
    exp_q = '{32'hF5280001, 32'h000200FF, 32'h000000FF, 32'hFE000001};
    check_stream("raw8_frame");
    chk("raw8_frame_cnt", 32'(frame_cnt), 32'd2);

    // pixel completing a pair on le; fe together with le and odd pixel
    data_type = 6'h2B;
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(8);
    ev(0, 0, 0, 1, 1, 10'd9);
    ev(0, 0, 1, 0, 0, 0);
    pix(5); pix(6); pix(7);
    ev(0, 1, 0, 1, 0, 0);
    exp_q = '{32'hF52B0002, 32'h00090008, 32'h00060005, 32'h00000007, 32'hFE000002};
    check_stream("fe_with_le");
    chk("fe_with_le_frame_int", 32'(fi_count), 32'd3);

    // fs without fe, new frame disabled: old trailer only, back to IDLE
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(1); pix(2);
    ev(0, 0, 0, 1, 0, 0);
    enable = 1'b0;
    ev(1, 0, 0, 0, 0, 0);
    exp_q = '{32'hF52B0003, 32'h00020001, 32'hFE000001};
    check_stream("missing_fe");
    chk("missing_fe_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("missing_fe_state", 32'(fsm_state), 32'd0);
    enable = 1'b1;

    // backpressure: fifth push into a full queue overflows
    wr_full = 1'b1;
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(1); pix(2); pix(3); pix(4); pix(5); pix(6); pix(7); pix(8);
    @(negedge pclk);
    chk("ovf_set", 32'(ovf_sticky), 32'd1);
    chk("ovf_state_drop", 32'(fsm_state), 32'd2);
    chk("ovf_stall_wr_en", 32'(wr_en), 32'd0);
    @(posedge pclk); #1;
    pix(9);
    ev(0, 0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0, 0);
    chk("ovf_frame_cnt", 32'(frame_cnt), 32'd4);
    wr_full = 1'b0;
    exp_q = '{32'hF52B0004, 32'h00020001, 32'h00040003, 32'h00060005};
    check_stream("ovf_drain");
    chk("ovf_no_frame_int", 32'(fi_count), 32'd4);
    chk("ovf_held", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf_sticky), 32'd0);
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 1, 0, 0, 0, 0);
    exp_q = '{32'hF52B0004, 32'hFE000000};
    check_stream("after_ovf");
    chk("after_ovf_frame_cnt", 32'(frame_cnt), 32'd5);

    // frame_cnt wrap: 251 more frames bring it to 256 -> 0
    for (int i = 0; i < 251; i++) begin
      ev(1, 0, 0, 0, 0, 0);
      ev(0, 1, 0, 0, 0, 0);
    end
    idle(12);
    got_q.delete();
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 1, 0, 0, 0, 0);
    exp_q = '{32'hF52B0000, 32'hFE000000};
    check_stream("wrap_header");

    // reset mid-line with words held in the queue
    wr_full = 1'b1;
    ev(1, 0, 0, 0, 0, 0);
    ev(0, 0, 1, 0, 0, 0);
    pix(1); pix(2); pix(3);
    reset_n = 1'b0;
    #2;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_state", 32'(fsm_state), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    wr_full = 1'b0;
    @(negedge pclk);
    chk("midrst_wr_data", wr_data, 32'h0);
    @(posedge pclk); #1;
    reset_n = 1'b1;
    idle(2);
    chk("midrst_empty", 32'(wr_en), 32'd0);
    ev(0, 0, 1, 0, 0, 0);
    pix(4); pix(5);
    ev(0, 0, 0, 1, 0, 0);
    ev(0, 1, 0, 0, 0, 0);
    check_stream("no_fs_line");
    chk("no_fs_state", 32'(fsm_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
